// File: rtl/m_timer_ctrl.sv
// Programmable count-to-P timer: one-shot or periodic, with pause/resume,
// a one-cycle terminal-count pulse and a sticky terminal-count flag.
module m_timer_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             i_ck,
    input  logic             i_res,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clr,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_period,
    output logic [WIDTH-1:0] o_cnt,
    output logic [1:0]       o_state,
    output logic             o_busy,
    output logic             o_tc,
    output logic             o_flag
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_pq;
    logic             r_mq;
    logic             r_tc;
    logic             r_flag;

    logic             w_terminal;
    logic             w_arm;

    assign w_terminal = (r_state == ST_RUN) && (r_cnt == r_pq);
    assign w_arm      = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start;

    // Period and mode are only sampled on arm, so live input changes never disturb a running count.
    always_ff @(posedge i_ck) begin
        if (!i_res) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pq    <= '0;
            r_mq    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_arm) begin
                        r_pq    <= i_period;
                        r_mq    <= i_mode;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_terminal) begin
                        r_cnt <= '0;
                        if (!r_mq)
                            r_state <= ST_DONE;
                        else if (i_stop)
                            r_state <= ST_PAUSE;
                        else
                            r_state <= ST_RUN;
                    end else if (i_stop) begin
                        r_state <= ST_PAUSE;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                ST_PAUSE: begin
                    if (!i_stop && i_start)
                        r_state <= ST_RUN;
                end
                ST_DONE: begin
                    r_cnt <= '0;
                    if (w_arm) begin
                        r_pq    <= i_period;
                        r_mq    <= i_mode;
                        r_state <= ST_RUN;
                    end else if (i_stop) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // A terminal edge sets the flag even when clr is asserted on the same edge.
    always_ff @(posedge i_ck) begin
        if (!i_res) begin
            r_tc   <= 1'b0;
            r_flag <= 1'b0;
        end else begin
            r_tc <= w_terminal;
            if (w_terminal)
                r_flag <= 1'b1;
            else if (i_clr)
                r_flag <= 1'b0;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_state = r_state;
    assign o_busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign o_tc    = r_tc;
    assign o_flag  = r_flag;

endmodule

// File: tb/tb_m_timer_ctrl.sv
// Scoreboard bench for m_timer_ctrl: directed vectors push hand-computed
// expectations, a monitor pops one per clock and compares.
module tb_m_timer_ctrl;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] P = 2'b10;
    localparam logic [1:0] D = 2'b11;

    typedef struct packed {
        int         id;
        logic [1:0] st;
        logic [3:0] cnt;
        logic       tc;
        logic       flag;
        logic       busy;
    } exp_t;

    logic       ck = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clr = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] period = 4'd0;
    logic [3:0] oCnt;
    logic [1:0] oState;
    logic       oBusy;
    logic       oTc;
    logic       oFlag;

    exp_t expQ[$];
    int   compared = 0;
    int   mismatched = 0;
    int   vecId = 0;

    m_timer_ctrl #(.WIDTH(4)) dut (
        .i_ck     (ck),
        .i_res    (res),
        .i_start  (start),
        .i_stop   (stop),
        .i_clr    (clr),
        .i_mode   (mode),
        .i_period (period),
        .o_cnt    (oCnt),
        .o_state  (oState),
        .o_busy   (oBusy),
        .o_tc     (oTc),
        .o_flag   (oFlag)
    );

    always #5 ck = ~ck;

    // Drive inputs on the falling edge; the expectation is for the outputs after the next rising edge.
    task automatic applyStimulus(input logic vRes, input logic vStart, input logic vStop,
                                 input logic vClr, input logic vMode, input logic [3:0] vPeriod,
                                 input logic [1:0] eSt, input logic [3:0] eCnt,
                                 input logic eTc, input logic eFlag);
        exp_t e;
        @(negedge ck);
        res    = vRes;
        start  = vStart;
        stop   = vStop;
        clr    = vClr;
        mode   = vMode;
        period = vPeriod;
        vecId++;
        e.id   = vecId;
        e.st   = eSt;
        e.cnt  = eCnt;
        e.tc   = eTc;
        e.flag = eFlag;
        e.busy = (eSt == R) || (eSt == P);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if ({oState, oCnt, oTc, oFlag, oBusy} !== {e.st, e.cnt, e.tc, e.flag, e.busy}) begin
            mismatched++;
            $display("[TB] FAIL vec%0d: got state=%0d cnt=%0d tc=%0b flag=%0b busy=%0b, required state=%0d cnt=%0d tc=%0b flag=%0b busy=%0b",
                     e.id, oState, oCnt, oTc, oFlag, oBusy, e.st, e.cnt, e.tc, e.flag, e.busy);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge ck);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        // reset, start ignored while res=0
        applyStimulus(0,1,0,0,0,4'd0,  I,4'd0,0,0);
        applyStimulus(0,0,0,0,0,4'd0,  I,4'd0,0,0);
        // one-shot, period 3
        applyStimulus(1,1,0,0,0,4'd3,  R,4'd0,0,0);
        applyStimulus(1,0,0,0,0,4'd3,  R,4'd1,0,0);
        applyStimulus(1,0,0,0,0,4'd3,  R,4'd2,0,0);
        applyStimulus(1,0,0,0,0,4'd3,  R,4'd3,0,0);
        applyStimulus(1,0,0,0,0,4'd3,  D,4'd0,1,1);
        applyStimulus(1,0,0,0,0,4'd3,  D,4'd0,0,1);
        // stop in DONE -> IDLE, stop in IDLE has no effect, then clear flag
        applyStimulus(1,0,1,0,0,4'd3,  I,4'd0,0,1);
        applyStimulus(1,0,1,0,0,4'd3,  I,4'd0,0,1);
        applyStimulus(1,0,0,1,0,4'd3,  I,4'd0,0,0);
        // periodic, period 2; start held and period changed while running
        applyStimulus(1,1,0,0,1,4'd2,  R,4'd0,0,0);
        applyStimulus(1,1,0,0,0,4'd7,  R,4'd1,0,0);
        applyStimulus(1,1,0,0,0,4'd7,  R,4'd2,0,0);
        applyStimulus(1,0,0,0,0,4'd7,  R,4'd0,1,1);
        applyStimulus(1,0,0,0,0,4'd7,  R,4'd1,0,1);
        applyStimulus(1,0,0,0,0,4'd7,  R,4'd2,0,1);
        applyStimulus(1,0,0,0,0,4'd7,  R,4'd0,1,1);
        applyStimulus(1,0,0,0,0,4'd7,  R,4'd1,0,1);
        // clr before, on and after a terminal edge
        applyStimulus(1,0,0,1,0,4'd7,  R,4'd2,0,0);
        applyStimulus(1,0,0,1,0,4'd7,  R,4'd0,1,1);
        applyStimulus(1,0,0,1,0,4'd7,  R,4'd1,0,0);
        applyStimulus(1,0,0,0,0,4'd7,  R,4'd2,0,0);
        // stop on periodic terminal edge -> PAUSE with cnt 0
        applyStimulus(1,0,1,0,0,4'd7,  P,4'd0,1,1);
        applyStimulus(1,1,1,0,0,4'd7,  P,4'd0,0,1);
        applyStimulus(1,1,0,0,0,4'd7,  R,4'd0,0,1);
        applyStimulus(1,0,0,0,0,4'd7,  R,4'd1,0,1);
        // stop on non-terminal edge holds cnt
        applyStimulus(1,0,1,0,0,4'd7,  P,4'd1,0,1);
        applyStimulus(1,0,0,0,0,4'd7,  P,4'd1,0,1);
        applyStimulus(1,1,0,0,0,4'd7,  R,4'd1,0,1);
        applyStimulus(1,0,0,0,0,4'd7,  R,4'd2,0,1);
        applyStimulus(1,0,0,0,0,4'd7,  R,4'd0,1,1);
        // pause/resume, period 5 one-shot
        applyStimulus(0,0,0,0,0,4'd7,  I,4'd0,0,0);
        applyStimulus(1,1,0,0,0,4'd5,  R,4'd0,0,0);
        applyStimulus(1,0,0,0,0,4'd5,  R,4'd1,0,0);
        applyStimulus(1,0,0,0,0,4'd5,  R,4'd2,0,0);
        applyStimulus(1,0,1,0,0,4'd5,  P,4'd2,0,0);
        applyStimulus(1,0,1,0,0,4'd5,  P,4'd2,0,0);
        applyStimulus(1,0,1,0,0,4'd5,  P,4'd2,0,0);
        applyStimulus(1,1,0,0,0,4'd5,  R,4'd2,0,0);
        applyStimulus(1,0,0,0,0,4'd5,  R,4'd3,0,0);
        applyStimulus(1,0,0,0,0,4'd5,  R,4'd4,0,0);
        applyStimulus(1,0,0,0,0,4'd5,  R,4'd5,0,0);
        applyStimulus(1,0,0,0,0,4'd5,  D,4'd0,1,1);
        // start+stop in DONE re-arms; period 15 counts to 15 with no wrap
        applyStimulus(1,1,1,0,0,4'd15, R,4'd0,0,1);
        for (int i = 1; i <= 15; i++)
            applyStimulus(1,0,0,0,0,4'd15, R,4'(i),0,1);
        applyStimulus(1,0,0,0,0,4'd15, D,4'd0,1,1);
        // period 0 periodic: tc held high
        applyStimulus(1,1,0,0,1,4'd0,  R,4'd0,0,1);
        applyStimulus(1,0,0,0,1,4'd0,  R,4'd0,1,1);
        applyStimulus(1,0,0,0,1,4'd0,  R,4'd0,1,1);
        applyStimulus(1,0,0,0,1,4'd0,  R,4'd0,1,1);
        applyStimulus(1,0,1,0,1,4'd0,  P,4'd0,1,1);
        // reset in PAUSE, then reset at cnt=3 in RUN with start asserted
        applyStimulus(0,0,0,0,0,4'd0,  I,4'd0,0,0);
        applyStimulus(1,1,0,0,1,4'd6,  R,4'd0,0,0);
        applyStimulus(1,0,0,0,1,4'd6,  R,4'd1,0,0);
        applyStimulus(1,0,0,0,1,4'd6,  R,4'd2,0,0);
        applyStimulus(1,0,0,0,1,4'd6,  R,4'd3,0,0);
        applyStimulus(0,1,0,0,1,4'd6,  I,4'd0,0,0);
        applyStimulus(1,0,0,0,1,4'd6,  I,4'd0,0,0);
        // period 0 one-shot: single tc then DONE
        applyStimulus(1,1,0,0,0,4'd0,  R,4'd0,0,0);
        applyStimulus(1,0,0,0,0,4'd0,  D,4'd0,1,1);
        applyStimulus(1,0,0,0,0,4'd0,  D,4'd0,0,1);

        for (int k = 0; k < 10 && expQ.size() != 0; k++) begin
            @(posedge ck);
            #2;
        end
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expectations, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/m_timer_ctrl.md
M_TIMER_CTRL -- requirements
Module: m_timer_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, width of count register and period value.
REQ-002 Port: ck  input  1  clock; all state updates on posedge ck.
REQ-003 Port: res  input  1  reset, synchronous and active-low; sampled on posedge ck; res=0 resets block.
REQ-004 Port: start  input  1  level, sampled each edge; arm/resume request.
REQ-005 Port: stop  input  1  level, sampled each edge; pause/abort request.
REQ-006 Port: clr  input  1  clears sticky flag.
REQ-007 Port: mode  input  1  0 = one-shot, 1 = periodic; captured at arm.
REQ-008 Port: period  input  WIDTH  terminal count P; captured at arm.
REQ-009 Port: cnt  output  WIDTH  current count, registered.
REQ-010 Port: state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-011 Port: busy  output  1  high when state is RUN or PAUSE; decoded from state register.
REQ-012 Port: tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-013 Port: flag  output  1  sticky terminal-count flag.

Function
REQ-014 Arm: in IDLE or DONE, start=1 SHALL capture period into P_q and mode into M_q, set cnt=0, and enter RUN on the same edge.
REQ-015 RUN, cnt!=P_q: each edge SHALL set cnt=cnt+1, tc=0.
REQ-016 RUN, cnt==P_q (terminal edge): SHALL set cnt=0, tc=1, flag=1; next state DONE if M_q=0, RUN if M_q=1.
REQ-017 Latency: arm at edge k SHALL give the first tc=1 after edge k+P+1; periodic mode repeats tc every P+1 cycles.
REQ-018 P_q=0: every RUN edge is terminal; periodic mode SHALL hold tc=1 continuously, one-shot mode gives one tc then DONE.
REQ-019 Count SHALL never exceed P_q; no wrap past 2^WIDTH-1, since P_q <= 2^WIDTH-1.
REQ-020 RUN with stop=1 (non-terminal edge): SHALL enter PAUSE, cnt held, tc=0.
REQ-021 RUN terminal edge with stop=1: terminal action (REQ-016) SHALL occur; next state DONE if M_q=0, PAUSE with cnt=0 if M_q=1.
REQ-022 PAUSE: cnt SHALL hold; start=1 and stop=0 SHALL return to RUN without re-capturing period/mode; count resumes on the following edge.
REQ-023 stop SHALL take priority over start whenever both are 1 in RUN or PAUSE (state stays/becomes PAUSE).
REQ-024 start=1 in RUN SHALL be ignored (no restart, no re-capture).
REQ-025 DONE: cnt=0, tc=0; stop=1 (start=0) SHALL enter IDLE; start=1 re-arms per REQ-014, with start taking priority over stop.
REQ-026 IDLE: stop SHALL have no effect; cnt=0.
REQ-027 tc SHALL be 0 on every edge that is not a terminal edge.
REQ-028 flag: clr=1 SHALL clear flag; on a terminal edge with clr=1, set SHALL win (flag=1).
REQ-029 period/mode changes SHALL take effect only at the next arm.

Reset
REQ-030 res=0 at an edge SHALL force state=IDLE, cnt=0, tc=0, flag=0, P_q=0, M_q=0, overriding all other inputs.
REQ-031 Reset during RUN or PAUSE SHALL abort without producing tc or setting flag.
REQ-032 No output SHALL change except at posedge ck; reset has no asynchronous path.

Verification
REQ-033 One-shot: period=3, mode=0, start pulse -> cnt 0,1,2,3,0; tc=1 exactly one cycle, 4 cycles after arm; state DONE; flag=1.
REQ-034 Periodic: period=2, mode=1, start held 1 cycle -> tc every 3 cycles; state stays RUN; start held high in RUN causes no restart.
REQ-035 Pause/resume: period=5, stop at cnt=2 for 3 cycles, then start -> cnt holds 2, resumes 3,4,5; tc 6 cycles of RUN after arm.
REQ-036 Boundaries: period=0, mode=1 -> tc constant 1; period=15 (WIDTH=4) -> cnt reaches 15 with no wrap, then 0 with tc; start+stop together in PAUSE -> stays PAUSE.
REQ-037 flag: clr asserted on the terminal edge -> flag=1; clr on the following edge -> flag=0.
REQ-038 Reset: res=0 at cnt=3 in RUN -> next edge all outputs 0, IDLE, no tc; start while res=0 is ignored.
